// File: rtl/riscv_pkg.sv
// Shared opcodes, format enum and decoded-instruction record for the RV32I/RV64I decode stage.
// XLEN-wide values (pc, imm) travel next to decoded_t because a package cannot be parameterised.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [31:0] insn;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        fmt_e        fmt;
        logic        illegal;
        logic        is_muldiv;
    } decoded_t;

endpackage

// File: rtl/riscv_insn_fields_decode.sv
// Combinational field extraction, format classification, immediate generation and legality check.
// Define RISCV_DECODE_M_EN to accept the M-extension encodings (funct7=0000001 on OP/OP-32).
module riscv_insn_fields_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     insn,
    output decoded_t        dec,
    output logic [XLEN-1:0] imm
);

`ifdef RISCV_DECODE_M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        logic signed [XLEN-1:0] w;
        w = v;
        return w;
    endfunction

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    fmt_e              fmt;
    logic              illegal;
    logic              muldiv;
    logic signed [31:0] imm32;

    assign opc = insn[6:0];
    assign f3  = insn[14:12];
    assign f7  = insn[31:25];

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        muldiv  = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL:            fmt = FMT_J;
            OPC_JALR, OPC_OP_IMM, OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
            OPC_OP_IMM_32: begin
                fmt = FMT_I;
                if (XLEN == 32) illegal = 1'b1;
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                if (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)))
                    illegal = 1'b1;
            end
            OPC_STORE: begin
                fmt = FMT_S;
                if (f3 >= ((XLEN == 32) ? 3'd3 : 3'd4)) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
            end
            OPC_OP, OPC_OP_32: begin
                fmt = FMT_R;
                if (opc == OPC_OP_32 && XLEN == 32) illegal = 1'b1;
                case (f7)
                    7'b0000000: ;
                    7'b0100000: if (f3 != 3'b000 && f3 != 3'b101) illegal = 1'b1;
                    7'b0000001: begin
                        if (M_EN) begin
                            muldiv = 1'b1;
                            // The word-sized M ops have no mulh/mulhsu/mulhu forms.
                            if (opc == OPC_OP_32 && f3 >= 3'b001 && f3 <= 3'b011) illegal = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (insn[1:0] != 2'b11) illegal = 1'b1;
        if (illegal) begin
            fmt    = FMT_NONE;
            muldiv = 1'b0;
        end
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{insn[31]}}, insn[31:20]};
            FMT_S:   imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            FMT_B:   imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            FMT_U:   imm32 = {insn[31:12], 12'b0};
            FMT_J:   imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = sext32(imm32);

    always_comb begin
        dec           = '0;
        dec.insn      = insn;
        dec.opcode    = opc;
        dec.rd        = insn[11:7];
        dec.funct3    = f3;
        dec.rs1       = insn[19:15];
        dec.rs2       = insn[24:20];
        dec.funct7    = f7;
        dec.fmt       = fmt;
        dec.illegal   = illegal;
        dec.is_muldiv = muldiv;
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I/RV64I decode stage with a 2-entry skid buffer (output register + skid register).
// Optional M-extension decode is enabled by defining RISCV_DECODE_M_EN.
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_insn,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output fmt_e            out_fmt,
    output logic            out_illegal,
    output logic            out_is_muldiv
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("riscv_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        decoded_t        dec;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{dec: '0, imm: '0, pc: PC_RESET};

    decoded_t        in_dec;
    logic [XLEN-1:0] in_imm;
    entry_t          new_entry;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept, drain;

    riscv_insn_fields_decode #(
        .XLEN(XLEN)
    ) u_fields (
        .insn(in_insn),
        .dec (in_dec),
        .imm (in_imm)
    );

    assign new_entry = '{dec: in_dec, imm: in_imm, pc: in_pc};

    // in_ready is a pure function of registered state, so it never follows out_ready.
    assign in_ready = rst_n && !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= RESET_ENTRY;
            skid_q       <= RESET_ENTRY;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_q.pc;
    assign out_imm       = out_q.imm;
    assign out_insn      = out_q.dec.insn;
    assign out_opcode    = out_q.dec.opcode;
    assign out_rd        = out_q.dec.rd;
    assign out_funct3    = out_q.dec.funct3;
    assign out_rs1       = out_q.dec.rs1;
    assign out_rs2       = out_q.dec.rs2;
    assign out_funct7    = out_q.dec.funct7;
    assign out_fmt       = out_q.dec.fmt;
    assign out_illegal   = out_q.dec.illegal;
    assign out_is_muldiv = out_q.dec.is_muldiv;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: XLEN=32 and XLEN=64 instances share one stimulus stream,
// checked against a FIFO-of-two model and a rule-based decode model.
module tb_riscv_decode_stage;
    import riscv_pkg::*;

`ifdef RISCV_DECODE_M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam logic [31:0] PC_RST32 = 32'h0000_0100;
    localparam logic [63:0] PC_RST64 = 64'h0000_0000_0000_0200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_insn, in_pc;

    logic        in_ready32, out_valid32, ill32, md32;
    logic [31:0] out_pc32, out_insn32, imm32;
    logic [6:0]  opc32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32;
    fmt_e        fmt32;

    logic        in_ready64, out_valid64, ill64, md64;
    logic [63:0] out_pc64, imm64;
    logic [31:0] out_insn64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64;
    fmt_e        fmt64;

    riscv_decode_stage #(.XLEN(32), .PC_RESET(PC_RST32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_insn(in_insn), .in_pc(in_pc), .out_valid(out_valid32), .out_ready(out_ready),
        .out_pc(out_pc32), .out_insn(out_insn32), .out_opcode(opc32), .out_rd(rd32),
        .out_funct3(f3_32), .out_rs1(rs1_32), .out_rs2(rs2_32), .out_funct7(f7_32),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_is_muldiv(md32)
    );

    riscv_decode_stage #(.XLEN(64), .PC_RESET(PC_RST64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_insn(in_insn), .in_pc({32'h0, in_pc}), .out_valid(out_valid64), .out_ready(out_ready),
        .out_pc(out_pc64), .out_insn(out_insn64), .out_opcode(opc64), .out_rd(rd64),
        .out_funct3(f3_64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_funct7(f7_64),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_is_muldiv(md64)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] imm;
        int          fmt;
        bit          ill;
        bit          md;
    } exp_t;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];

    // Format numbering follows fmt_e order: R=0 I=1 S=2 B=3 U=4 J=5 NONE=6.
    function automatic exp_t ref_decode(input logic [31:0] w, input int xlen);
        exp_t   e;
        int     opc, f3, f7;
        longint simm;
        opc = int'(w[6:0]);
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        e.fmt = 6; e.ill = 1'b0; e.md = 1'b0;
        case (opc)
            'h37, 'h17:             e.fmt = 4;
            'h6f:                   e.fmt = 5;
            'h67, 'h13, 'h73, 'h0f: e.fmt = 1;
            'h1b: begin e.fmt = 1; e.ill = (xlen == 32); end
            'h03: begin e.fmt = 1; e.ill = (f3 == 7) || (xlen == 32 && (f3 == 3 || f3 == 6)); end
            'h23: begin e.fmt = 2; e.ill = (f3 >= ((xlen == 32) ? 3 : 4)); end
            'h63: begin e.fmt = 3; e.ill = (f3 == 2 || f3 == 3); end
            'h33, 'h3b: begin
                e.fmt = 0;
                if (opc == 'h3b && xlen == 32) e.ill = 1'b1;
                if (f7 == 'h20) begin
                    if (!(f3 == 0 || f3 == 5)) e.ill = 1'b1;
                end else if (f7 == 1) begin
                    if (!M_EN) e.ill = 1'b1;
                    else begin
                        e.md = 1'b1;
                        if (opc == 'h3b && f3 >= 1 && f3 <= 3) e.ill = 1'b1;
                    end
                end else if (f7 != 0) begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        if (w[1:0] != 2'b11) e.ill = 1'b1;
        if (e.ill) begin e.fmt = 6; e.md = 1'b0; end
        case (e.fmt)
            1: simm = longint'($signed(w[31:20]));
            2: simm = longint'($signed({w[31:25], w[11:7]}));
            3: simm = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            4: simm = longint'($signed({w[31:12], 12'h000}));
            5: simm = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: simm = 0;
        endcase
        e.imm = (xlen == 32) ? {32'h0, simm[31:0]} : simm;
        return e;
    endfunction

    task automatic check_state();
        exp_t e32, e64;
        ent_t h;
        check_val("in_ready32", 64'(in_ready32), 64'(rst_n && q.size() < 2));
        check_val("in_ready64", 64'(in_ready64), 64'(rst_n && q.size() < 2));
        check_val("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        check_val("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            h   = q[0];
            e32 = ref_decode(h.insn, 32);
            e64 = ref_decode(h.insn, 64);
            check_val("pc32", 64'(out_pc32), 64'(h.pc));
            check_val("insn32", 64'(out_insn32), 64'(h.insn));
            check_val("fields32", 64'({opc32, rd32, f3_32, rs1_32, rs2_32, f7_32}),
                      64'({h.insn[6:0], h.insn[11:7], h.insn[14:12], h.insn[19:15], h.insn[24:20], h.insn[31:25]}));
            check_val("imm32", 64'(imm32), e32.imm);
            check_val("fmt32", 64'(fmt32), 64'(e32.fmt));
            check_val("illegal32", 64'(ill32), 64'(e32.ill));
            check_val("muldiv32", 64'(md32), 64'(e32.md));
            check_val("pc64", out_pc64, {32'h0, h.pc});
            check_val("insn64", 64'(out_insn64), 64'(h.insn));
            check_val("fields64", 64'({opc64, rd64, f3_64, rs1_64, rs2_64, f7_64}),
                      64'({h.insn[6:0], h.insn[11:7], h.insn[14:12], h.insn[19:15], h.insn[24:20], h.insn[31:25]}));
            check_val("imm64", imm64, e64.imm);
            check_val("fmt64", 64'(fmt64), 64'(e64.fmt));
            check_val("illegal64", 64'(ill64), 64'(e64.ill));
            check_val("muldiv64", 64'(md64), 64'(e64.md));
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                         input logic rdy, input logic fl, input logic rn);
        bit acc, drn;
        @(negedge clk);
        in_valid = v; in_insn = insn; in_pc = pc; out_ready = rdy; flush = fl; rst_n = rn;
        #1;
        check_state();
        acc = rn && v && (q.size() < 2);
        drn = (q.size() > 0) && rdy;
        @(posedge clk);
        if (!rn || fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{insn: insn, pc: pc});
        end
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) == 0) return w;
        case ($urandom_range(0, 14))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6f;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8:  w[6:0] = 7'h1b;
            9:  w[6:0] = 7'h33;
            10: w[6:0] = 7'h3b;
            11: w[6:0] = 7'h0f;
            12: w[6:0] = 7'h73;
            13: w[6:0] = 7'h33;
            default: w[1:0] = 2'b11;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_ctr;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_insn = 32'h0; in_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 64'(in_ready32), 64'(0));
        check_val("rst_out_valid", 64'(out_valid32), 64'(0));
        check_val("rst_pc32", 64'(out_pc32), 64'(PC_RST32));
        check_val("rst_pc64", out_pc64, PC_RST64);
        check_val("rst_data", 64'({out_insn32, imm32}), 64'(0));
        check_val("rst_flags", 64'({fmt32, ill32, md32}), 64'(0));

        // Single decodes with a free-running consumer.
        cycle(1, 32'hFFF00093, 32'h10, 1, 0, 1); #2;
        check_val("addi_valid", 64'(out_valid32), 64'(1));
        check_val("addi_rd", 64'(rd32), 64'(1));
        check_val("addi_fmt", 64'(fmt32), 64'(1));
        check_val("addi_imm32", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
        check_val("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("addi_illegal", 64'(ill32), 64'(0));
        cycle(1, 32'hFE000EE3, 32'h14, 1, 0, 1); #2;
        check_val("beq_fmt", 64'(fmt32), 64'(3));
        check_val("beq_imm32", 64'(imm32), 64'h0000_0000_FFFF_FFFC);
        check_val("beq_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1, 32'h0000_0000, 32'h18, 1, 0, 1); #2;
        check_val("zero_illegal", 64'(ill32), 64'(1));
        check_val("zero_fmt", 64'(fmt32), 64'(6));
        check_val("zero_imm", 64'(imm32), 64'(0));
        cycle(1, 32'h022081B3, 32'h1C, 1, 0, 1); #2;
        check_val("mul_muldiv", 64'(md32), 64'(M_EN));
        check_val("mul_illegal", 64'(ill32), 64'(!M_EN));
        cycle(1, 32'h800000B7, 32'h20, 1, 0, 1); #2;
        check_val("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        check_val("lui_imm32", 64'(imm32), 64'h0000_0000_8000_0000);
        check_val("lui_fmt", 64'(fmt64), 64'(4));
        cycle(0, 32'h0, 32'h0, 1, 0, 1);

        // Backpressure: two accepted, then stall; release drains in order.
        for (int i = 0; i < 3; i++) cycle(1, 32'h00100093 + (i << 7), 32'h100 + 32'(4 * i), 0, 0, 1);
        #2;
        check_val("bp_in_ready", 64'(in_ready32), 64'(0));
        check_val("bp_head_pc", 64'(out_pc32), 64'h100);
        cycle(0, 32'h0, 32'h0, 1, 0, 1); #2;
        check_val("bp_second_pc", 64'(out_pc32), 64'h104);
        cycle(0, 32'h0, 32'h0, 1, 0, 1); #2;
        check_val("bp_empty", 64'(out_valid32), 64'(0));

        // Flush with both entries full and an offered instruction.
        cycle(1, 32'h00000013, 32'h200, 0, 0, 1);
        cycle(1, 32'h00000013, 32'h204, 0, 0, 1);
        cycle(1, 32'h00000013, 32'h208, 0, 1, 1); #2;
        check_val("flush_valid", 64'(out_valid32), 64'(0));
        check_val("flush_in_ready", 64'(in_ready32), 64'(1));
        cycle(1, 32'h00000013, 32'h300, 1, 1, 1); #2;
        check_val("flush_drops_accept", 64'(out_valid64), 64'(0));
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0, 1);

        // Reset in the middle of a stream.
        cycle(1, 32'h00000013, 32'h400, 0, 0, 1);
        cycle(1, 32'h00000013, 32'h404, 0, 0, 1);
        cycle(1, 32'h00000013, 32'h408, 0, 0, 0); #2;
        check_val("mid_rst_valid", 64'(out_valid32), 64'(0));
        check_val("mid_rst_pc32", 64'(out_pc32), 64'(PC_RST32));
        check_val("mid_rst_pc64", out_pc64, PC_RST64);
        check_val("mid_rst_in_ready", 64'(in_ready64), 64'(0));

        pc_ctr = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_insn(), pc_ctr,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 99) != 0);
            pc_ctr = pc_ctr + 32'd4;
        end
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
